sdram_mem_tester: RTL and testbench

//  Self-contained SDRAM built-in self-test engine. Replaces the PC-driven write/read-back test

---
 rtl/sdram_mem_tester_pkg.sv | 28 ++
 rtl/sdram_mem_tester_if.sv | 19 +
 rtl/sdram_tst_pattern_gen.sv | 55 +++++
 rtl/sdram_mem_tester.sv | 182 ++++++++++++++++++
 tb/tb_sdram_mem_tester.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_mem_tester_pkg.sv
// Shared encodings for the SDRAM built-in self-test engine: pattern modes,
// FSM states and the LFSR polynomial used by the pseudo-random mode.
package sdram_mem_tester_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR    = 2'd0,  // address as data
    MODE_LFSR    = 2'd1,  // pseudo-random
    MODE_CHECKER = 2'd2,  // 0x55../0xAA.. by address parity
    MODE_CONST   = 2'd3   // user constant
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DONE
  } state_e;

  // Right-shifting Galois form of the taps 32,22,2,1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/sdram_mem_tester_if.sv
// Request/completion handshake between the self-test engine and SdramCtrl.
interface sdram_mem_tester_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16
);
  logic                  rd;        // read request
  logic                  wr;        // write request
  logic [ADDR_WIDTH-1:0] addr;      // request address
  logic [DATA_WIDTH-1:0] wr_data;   // write data
  logic                  op_begun;  // controller accepted the request
  logic                  wr_done;   // write complete pulse
  logic                  rd_done;   // read data valid pulse
  logic [DATA_WIDTH-1:0] rd_data;   // read data

  modport master (output rd, wr, addr, wr_data,
                  input  op_begun, wr_done, rd_done, rd_data);
  modport slave  (input  rd, wr, addr, wr_data,
                  output op_begun, wr_done, rd_done, rd_data);
endinterface

// File: rtl/sdram_tst_pattern_gen.sv
// Expected-word generator shared by the write and read phases. The LFSR is
// reseeded at the start of each phase and advanced once per completed word,
// so both phases reproduce the same sequence.
module sdram_tst_pattern_gen
  import sdram_mem_tester_pkg::*;
#(
  parameter int          ADDR_WIDTH = 23,
  parameter int          DATA_WIDTH = 16,
  parameter int          PASS_WIDTH = 8,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                  clk_i,
  input  logic                  rst_bi,
  input  mode_e                 mode_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  inv_i,          // pass index bit 0
  input  logic [DATA_WIDTH-1:0] const_i,
  input  logic                  reseed_i,
  input  logic [PASS_WIDTH-1:0] reseed_pass_i,  // pass the new phase belongs to
  input  logic                  advance_i,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [31:0]           lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] base;

  // LFSR next state: reseed wins over advance when both land on one cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    lfsr_d = lfsr_q;
    if (reseed_i)       lfsr_d = LFSR_SEED ^ 32'(reseed_pass_i);
    else if (advance_i) lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR state register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_bi) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  // Base pattern selection before the per-pass inversion.
  always_comb begin
    base = '0;
    unique case (mode_i)
      MODE_ADDR:    base = DATA_WIDTH'(addr_i);
      MODE_LFSR:    base = lfsr_q[DATA_WIDTH-1:0];
      MODE_CHECKER: for (int i = 0; i < DATA_WIDTH; i++) base[i] = ~(i[0] ^ addr_i[0]);
      MODE_CONST:   base = const_i;
    endcase
  end

  assign word_o = base ^ {DATA_WIDTH{inv_i}};

endmodule

// File: rtl/sdram_mem_tester.sv
// SDRAM built-in self-test: writes a pattern over an address range, reads it
// back and compares, for a number of passes; reports error count and the
// first mismatch. One request outstanding at a time, with a per-handshake
// watchdog and an abort that always completes an accepted operation.
module sdram_mem_tester
  import sdram_mem_tester_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 23,
  parameter int          DATA_WIDTH    = 16,
  parameter int          PASS_WIDTH    = 8,
  parameter int          ERR_CNT_WIDTH = 16,
  parameter int          TIMEOUT       = 1024,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
  input  logic                     clk_i,
  input  logic                     rst_bi,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [1:0]               mode_i,
  input  logic [DATA_WIDTH-1:0]    const_i,
  input  logic [ADDR_WIDTH-1:0]    startAddr_i,
  input  logic [ADDR_WIDTH-1:0]    endAddr_i,
  input  logic [PASS_WIDTH-1:0]    passes_i,
  sdram_mem_tester_if.master       bus,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic                     aborted_o,
  output logic [ERR_CNT_WIDTH-1:0] errCnt_o,
  output logic [ADDR_WIDTH-1:0]    errAddr_o,
  output logic [DATA_WIDTH-1:0]    errExp_o,
  output logic [DATA_WIDTH-1:0]    errAct_o
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic [DATA_WIDTH-1:0]    const_q, const_d;
  logic [ADDR_WIDTH-1:0]    start_q, start_d, end_q, end_d, addr_q, addr_d;
  logic [PASS_WIDTH-1:0]    passes_q, passes_d, pass_q, pass_d;
  logic [WDW-1:0]           wdog_q, wdog_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]    err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0]    err_exp_q, err_exp_d, err_act_q, err_act_d;
  logic                     timeout_q, timeout_d, aborted_q, aborted_d;
  logic                     abort_pend_q, abort_pend_d, empty_q, empty_d;

  logic                     reseed, advance, abort_any;
  logic [PASS_WIDTH-1:0]    reseed_pass;
  logic [DATA_WIDTH-1:0]    word;

  sdram_tst_pattern_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .PASS_WIDTH(PASS_WIDTH), .LFSR_SEED(LFSR_SEED)
  ) u_pattern_gen (
    .clk_i(clk_i), .rst_bi(rst_bi), .mode_i(mode_q), .addr_i(addr_q),
    .inv_i(pass_q[0]), .const_i(const_q), .reseed_i(reseed),
    .reseed_pass_i(reseed_pass), .advance_i(advance), .word_o(word)
  );

  // Next-state, datapath and watchdog decisions.
  always_comb begin
    state_d = state_q;       mode_d = mode_q;         const_d = const_q;
    start_d = start_q;       end_d = end_q;           addr_d = addr_q;
    passes_d = passes_q;     pass_d = pass_q;         wdog_d = '0;
    err_cnt_d = err_cnt_q;   err_addr_d = err_addr_q;
    err_exp_d = err_exp_q;   err_act_d = err_act_q;
    timeout_d = timeout_q;   aborted_d = aborted_q;
    abort_pend_d = abort_pend_q; empty_d = empty_q;
    reseed = 1'b0;  reseed_pass = pass_q;  advance = 1'b0;
    abort_any = abort_i | abort_pend_q;

    case (state_q)
      ST_IDLE, ST_DONE: if (start_i) begin
        mode_d     = mode_e'(mode_i);
        const_d    = const_i;
        start_d    = startAddr_i;
        end_d      = endAddr_i;
        passes_d   = (passes_i == '0) ? PASS_WIDTH'(1) : passes_i;
        pass_d     = '0;
        addr_d     = startAddr_i;
        err_cnt_d  = '0;  err_addr_d = '0;  err_exp_d = '0;  err_act_d = '0;
        timeout_d  = 1'b0;  aborted_d = 1'b0;  abort_pend_d = 1'b0;
        empty_d    = startAddr_i > endAddr_i;
        reseed     = 1'b1;
        reseed_pass = '0;
        state_d    = (startAddr_i > endAddr_i) ? ST_DONE : ST_WR_REQ;
      end
      ST_WR_REQ, ST_RD_REQ: begin
        abort_pend_d = abort_any;
        if (bus.op_begun) begin
          state_d = (state_q == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
        end else if (abort_any) begin
          state_d = ST_DONE;  aborted_d = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        abort_pend_d = abort_any;
        if (bus.wr_done) begin
          advance = 1'b1;
          if (abort_any) begin
            state_d = ST_DONE;  aborted_d = 1'b1;
          end else if (addr_q == end_q) begin
            state_d = ST_RD_REQ;  addr_d = start_q;  reseed = 1'b1;
          end else begin
            state_d = ST_WR_REQ;  addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_RD_WAIT: begin
        abort_pend_d = abort_any;
        if (bus.rd_done) begin
          advance = 1'b1;
          if (bus.rd_data != word) begin
            if (err_cnt_q == '0) begin
              err_addr_d = addr_q;  err_exp_d = word;  err_act_d = bus.rd_data;
            end
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
          if (abort_any) begin
            state_d = ST_DONE;  aborted_d = 1'b1;
          end else if (addr_q != end_q) begin
            state_d = ST_RD_REQ;  addr_d = addr_q + 1'b1;
          end else if (pass_q == passes_q - 1'b1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WR_REQ;  addr_d = start_q;  pass_d = pass_q + 1'b1;
            reseed = 1'b1;  reseed_pass = pass_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog runs only while a handshake makes no progress.
    if (busy_o && state_d == state_q) begin
      if (wdog_q == WDW'(TIMEOUT - 1)) begin
        state_d = ST_DONE;  timeout_d = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_bi) begin
      state_q <= ST_IDLE;   mode_q <= MODE_ADDR;  const_q <= '0;
      start_q <= '0;        end_q <= '0;          addr_q <= '0;
      passes_q <= '0;       pass_q <= '0;         wdog_q <= '0;
      err_cnt_q <= '0;      err_addr_q <= '0;     err_exp_q <= '0;  err_act_q <= '0;
      timeout_q <= 1'b0;    aborted_q <= 1'b0;    abort_pend_q <= 1'b0;  empty_q <= 1'b0;
    end else begin
      state_q <= state_d;   mode_q <= mode_d;     const_q <= const_d;
      start_q <= start_d;   end_q <= end_d;       addr_q <= addr_d;
      passes_q <= passes_d; pass_q <= pass_d;     wdog_q <= wdog_d;
      err_cnt_q <= err_cnt_d; err_addr_q <= err_addr_d;
      err_exp_q <= err_exp_d; err_act_q <= err_act_d;
      timeout_q <= timeout_d; aborted_q <= aborted_d;
      abort_pend_q <= abort_pend_d; empty_q <= empty_d;
    end
  end

  assign bus.wr      = (state_q == ST_WR_REQ);
  assign bus.rd      = (state_q == ST_RD_REQ);
  assign bus.addr    = (bus.wr | bus.rd) ? addr_q : '0;
  assign bus.wr_data = bus.wr ? word : '0;

  assign busy_o    = (state_q == ST_WR_REQ) | (state_q == ST_WR_WAIT) |
                     (state_q == ST_RD_REQ) | (state_q == ST_RD_WAIT);
  assign done_o    = (state_q == ST_DONE);
  assign pass_o    = done_o & (err_cnt_q == '0) & ~timeout_q & ~aborted_q & ~empty_q;
  assign timeout_o = timeout_q;
  assign aborted_o = aborted_q;
  assign errCnt_o  = err_cnt_q;
  assign errAddr_o = err_addr_q;
  assign errExp_o  = err_exp_q;
  assign errAct_o  = err_act_q;

endmodule

// File: tb/tb_sdram_mem_tester.sv
// Directed bench for sdram_mem_tester with a behavioural SdramCtrl model
// (accept delay / done delay, optional read corruption, optional no-accept).
module tb_sdram_mem_tester;
  localparam int AW = 23;
  localparam int DW = 16;

  logic clk, rst_b, start_in, abort_in;
  logic [1:0]    mode_in;
  logic [DW-1:0] const_in;
  logic [AW-1:0] sa_in, ea_in;
  logic [7:0]    passes_in;
  logic busy, done, pass_st, tmo, aborted;
  logic [1:0]    err_cnt;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp, err_act;

  sdram_mem_tester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_mem_tester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PASS_WIDTH(8),
                     .ERR_CNT_WIDTH(2), .TIMEOUT(1024)) dut (
    .clk_i(clk), .rst_bi(rst_b), .start_i(start_in), .abort_i(abort_in),
    .mode_i(mode_in), .const_i(const_in), .startAddr_i(sa_in), .endAddr_i(ea_in),
    .passes_i(passes_in), .bus(bus), .busy_o(busy), .done_o(done), .pass_o(pass_st),
    .timeout_o(tmo), .aborted_o(aborted), .errCnt_o(err_cnt), .errAddr_o(err_addr),
    .errExp_o(err_exp), .errAct_o(err_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model knobs (driven only by the stimulus block).
  int            accept_dly = 3, done_dly = 5;
  logic          never_accept, corrupt_all, flip_en;
  logic [AW-1:0] flip_addr;

  // Controller model state and observation counters.
  int            m_state = 0, m_cnt = 0;
  logic          m_is_rd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] wr_log [$];
  int            rd_req_cnt = 0, rd_acc = 0, rd_done_cnt = 0, last_rd_done_cyc = 0;

  // Behavioural SdramCtrl: reacts on the falling edge, away from the DUT edge.
  always @(negedge clk) begin
    bus.op_begun = 1'b0;  bus.wr_done = 1'b0;  bus.rd_done = 1'b0;
    if (!rst_b) begin
      m_state = 0;  bus.rd_data = '0;
    end else begin
      case (m_state)
        0: if ((bus.rd || bus.wr) && !never_accept) begin
             m_is_rd = bus.rd;
             if (bus.rd) rd_req_cnt++;
             m_cnt = accept_dly;  m_state = 1;
           end
        1: if (!(bus.rd || bus.wr)) m_state = 0;
           else begin
             m_cnt--;
             if (m_cnt == 0) begin
               bus.op_begun = 1'b1;  m_addr = bus.addr;  m_wdata = bus.wr_data;
               if (m_is_rd) rd_acc++; else wr_log.push_back(bus.wr_data);
               m_cnt = done_dly;  m_state = 2;
             end
           end
        default: begin
          m_cnt--;
          if (m_cnt == 0) begin
            if (m_is_rd) begin
              bus.rd_data = mem[m_addr[3:0]] ^
                ((corrupt_all || (flip_en && m_addr == flip_addr)) ? 16'h0001 : 16'h0000);
              bus.rd_done = 1'b1;  rd_done_cnt++;  last_rd_done_cyc = cyc;
            end else begin
              mem[m_addr[3:0]] = m_wdata;  bus.wr_done = 1'b1;
            end
            m_state = 0;
          end
        end
      endcase
    end
  end

  int n_checks = 0, n_fail = 0;
  int wr_base, rdq_base, rda_base, rdd_base, done_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Load config, pulse start for one cycle; returns on the falling edge after start was sampled.
  task automatic run(input logic [1:0] m, input logic [DW-1:0] c,
                     input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [7:0] p);
    wr_base = wr_log.size();  rdq_base = rd_req_cnt;
    rda_base = rd_acc;        rdd_base = rd_done_cnt;
    mode_in = m;  const_in = c;  sa_in = s;  ea_in = e;  passes_in = p;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: observed=running expected=finished");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int n;
    rst_b = 1'b0;  start_in = 1'b0;  abort_in = 1'b0;  mode_in = 2'd0;  const_in = '0;
    sa_in = '0;  ea_in = '0;  passes_in = 8'd1;
    never_accept = 1'b0;  corrupt_all = 1'b0;  flip_en = 1'b0;  flip_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_rd", 64'({bus.wr, bus.rd}), 64'd0);
    check("rst_pass_errcnt", 64'({pass_st, err_cnt}), 64'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // Address-as-data over 0..3, one pass.
    run(2'd0, '0, 23'd0, 23'd3, 8'd1);
    check("t1_wr_latency", 64'(bus.wr), 64'd1);
    wait_done("t1");
    check("t1_nwr", 64'(wr_log.size() - wr_base), 64'd4);
    for (int i = 0; i < 4; i++) check("t1_wdata", 64'(wr_log[wr_base + i]), 64'(i));
    check("t1_nrd", 64'(rd_done_cnt - rdd_base), 64'd4);
    check("t1_pass", 64'(pass_st), 64'd1);
    check("t1_errcnt", 64'(err_cnt), 64'd0);
    check("t1_done_latency", 64'(done_cyc - last_rd_done_cyc), 64'd1);

    // Single bit flip on the read of address 2.
    flip_en = 1'b1;  flip_addr = 23'd2;
    run(2'd0, '0, 23'd0, 23'd3, 8'd1);
    wait_done("t2");
    flip_en = 1'b0;
    check("t2_errcnt", 64'(err_cnt), 64'd1);
    check("t2_erraddr", 64'(err_addr), 64'd2);
    check("t2_errexp", 64'(err_exp), 64'h0002);
    check("t2_erract", 64'(err_act), 64'h0003);
    check("t2_pass", 64'(pass_st), 64'd0);

    // Checkerboard, two passes: second pass is inverted.
    run(2'd2, '0, 23'd0, 23'd1, 8'd2);
    wait_done("t3");
    check("t3_nwr", 64'(wr_log.size() - wr_base), 64'd4);
    check("t3_w0", 64'(wr_log[wr_base + 0]), 64'h5555);
    check("t3_w1", 64'(wr_log[wr_base + 1]), 64'hAAAA);
    check("t3_w2", 64'(wr_log[wr_base + 2]), 64'hAAAA);
    check("t3_w3", 64'(wr_log[wr_base + 3]), 64'h5555);
    check("t3_pass", 64'(pass_st), 64'd1);

    // LFSR mode: seed low bits, then one Galois step.
    run(2'd1, '0, 23'd0, 23'd1, 8'd1);
    wait_done("t4");
    check("t4_w0", 64'(wr_log[wr_base + 0]), 64'h2468);
    check("t4_w1", 64'(wr_log[wr_base + 1]), 64'h9234);
    check("t4_pass", 64'(pass_st), 64'd1);

    // Constant mode, pass count 0 treated as 1.
    run(2'd3, 16'h1234, 23'd4, 23'd4, 8'd0);
    wait_done("t5");
    check("t5_nwr", 64'(wr_log.size() - wr_base), 64'd1);
    check("t5_w0", 64'(wr_log[wr_base]), 64'h1234);
    check("t5_pass", 64'(pass_st), 64'd1);

    // Empty range: no operations, not a pass.
    run(2'd0, '0, 23'd5, 23'd3, 8'd1);
    check("t6_done", 64'(done), 64'd1);
    check("t6_pass_errcnt", 64'({pass_st, err_cnt}), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_nwr", 64'(wr_log.size() - wr_base), 64'd0);

    // Controller never accepts: request held for exactly TIMEOUT cycles.
    never_accept = 1'b1;
    run(2'd0, '0, 23'd0, 23'd3, 8'd1);
    n = 0;
    while (bus.wr && n < 2000) begin
      n++;
      @(negedge clk);
    end
    never_accept = 1'b0;
    check("t7_wr_cycles", 64'(n), 64'd1024);
    check("t7_timeout", 64'(tmo), 64'd1);
    check("t7_done", 64'(done), 64'd1);
    check("t7_pass", 64'(pass_st), 64'd0);

    // Abort while the 3rd read is outstanding.
    run(2'd0, '0, 23'd0, 23'd7, 8'd1);
    n = 0;
    while ((rd_acc - rda_base) < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t8_reach_rd3", 64'(rd_acc - rda_base), 64'd3);
    @(negedge clk);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    wait_done("t8");
    repeat (10) @(negedge clk);
    check("t8_rd_reqs", 64'(rd_req_cnt - rdq_base), 64'd3);
    check("t8_rd_done", 64'(rd_done_cnt - rdd_base), 64'd3);
    check("t8_aborted", 64'(aborted), 64'd1);
    check("t8_pass", 64'(pass_st), 64'd0);

    // Every read corrupted: 2-bit error counter saturates.
    corrupt_all = 1'b1;
    run(2'd0, '0, 23'd0, 23'd7, 8'd1);
    wait_done("t9");
    corrupt_all = 1'b0;
    check("t9_errcnt_sat", 64'(err_cnt), 64'd3);
    check("t9_erraddr", 64'(err_addr), 64'd0);
    check("t9_erract", 64'(err_act), 64'h0001);

    // Reset while a write is in flight.
    run(2'd0, '0, 23'd0, 23'd3, 8'd1);
    n = 0;
    while (wr_log.size() == wr_base && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t10_busy_before", 64'(busy), 64'd1);
    rst_b = 1'b0;
    @(negedge clk);
    check("t10_busy", 64'(busy), 64'd0);
    check("t10_wr_rd", 64'({bus.wr, bus.rd}), 64'd0);
    check("t10_done_flags", 64'({done, pass_st, tmo, aborted}), 64'd0);
    check("t10_addr_data", 64'({bus.addr, bus.wr_data}), 64'd0);
    rst_b = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
